if_fetch_buffer: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline. Sits directly upstream of decode; drives the instruction word and PC consumed by the decode stage and its immediate decoder.
- Owns the PC, issues word requests to a fixed-latency instruction memory and buffers returned words in a small FIFO.
- Presents the buffered words to decode with a valid/ready handshake.
- Handles redirects (branch/jump) by flushing buffered and in-flight fetches.

---
 rtl/if_pkg.sv | 15 +
 rtl/if_instr_fifo.sv | 42 ++++
 rtl/if_fetch_buffer.sv | 69 ++++++
 tb/tb_if_fetch_buffer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared constants, FIFO entry type and pointer-width helper for the fetch stage
package if_pkg;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/if_instr_fifo.sv
// if_instr_fifo: DEPTH-entry fetch FIFO with push, pop and synchronous flush
module if_instr_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [AW:0]  count,
  output logic         empty,
  output logic         full
);
  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_pop;
  assign empty  = count == '0;
  assign full   = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, do_pop};
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: RV32I fetch stage with PC, 1-cycle imem issue and decode FIFO; IF_PERF_CNT_EN enables perf_bubbles
module if_fetch_buffer
  import if_pkg::*;
#(
  parameter int              size     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [size-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [size-1:0] imem_addr,
  input  logic [size-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [size-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [size-1:0] id_instruction,
  output logic [size-1:0] id_pc,
  output logic [31:0]     perf_bubbles
);
  localparam int AW = clog2(DEPTH);
  logic [size-1:0] pc, pc_shadow;
  logic            inflight, drop, pop, capture, fifo_empty, fifo_full;
  logic [AW:0]     count;
  logic [AW+1:0]   occupancy;
  fetch_entry_t    head;
  assign pop       = id_valid && id_ready;
  assign capture   = inflight && !drop && !redirect_valid;
  assign occupancy = {1'b0, count} + {{(AW+1){1'b0}}, inflight} - {{(AW+1){1'b0}}, pop};
  assign imem_req  = rst_n && !redirect_valid && occupancy < (AW+2)'(DEPTH);
  assign imem_addr = pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc        <= RESET_PC;
      pc_shadow <= '0;
      inflight  <= 1'b0;
      drop      <= 1'b0;
    end else begin
      pc        <= redirect_valid ? redirect_pc & ~size'(3) : imem_req ? pc + size'(4) : pc;
      pc_shadow <= imem_req ? pc : pc_shadow;
      inflight  <= imem_req;
      drop      <= redirect_valid && inflight;
    end
  if_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (capture),
    .pop       (pop),
    .push_data ('{pc: pc_shadow, instr: imem_rdata}),
    .head      (head),
    .count     (count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );
  assign id_valid       = !fifo_empty;
  assign id_instruction = fifo_empty ? NOP_INSTR : head.instr;
  assign id_pc          = fifo_empty ? '0 : head.pc;
  // The issue rule leaves room for every in-flight word, so a capture can never meet a full FIFO
  assert property (@(posedge clk) disable iff (!rst_n) capture |-> !fifo_full);
`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) perf_bubbles <= '0;
    else if (!id_valid && !redirect_valid && perf_bubbles != '1) perf_bubbles <= perf_bubbles + 32'd1;
`else
  assign perf_bubbles = '0;
`endif
endmodule

// File: tb/tb_if_fetch_buffer.sv
// tb_if_fetch_buffer: scoreboard bench for if_fetch_buffer with a 1-cycle imem responder
module tb_if_fetch_buffer;
  logic        clk = 1'b0;
  logic        rst_n, imem_req, redirect_valid, id_ready, id_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, id_instruction, id_pc, perf_bubbles;
  logic [31:0] q[$];
  logic [31:0] mpc, perf_exp, h, e;
  int          n_chk = 0, n_pass = 0, occ;
  logic        p;

  if_fetch_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instruction (id_instruction),
    .id_pc          (id_pc),
    .perf_bubbles   (perf_bubbles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  always @(posedge clk) imem_rdata <= word(imem_addr);

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mpc      = 32'h0;
      perf_exp = 32'h0;
      chk("rst_valid", id_valid, 0);
      chk("rst_instr", id_instruction, 32'h0000_0013);
      chk("rst_pc", id_pc, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_perf", perf_bubbles, 0);
    end else begin
      p   = id_valid && id_ready && !redirect_valid;
      occ = q.size() - int'(p);
      chk("imem_req", imem_req, !redirect_valid && occ < 4);
`ifdef IF_PERF_CNT_EN
      chk("perf", perf_bubbles, perf_exp);
      if (!id_valid && !redirect_valid) perf_exp++;
`else
      chk("perf", perf_bubbles, 0);
`endif
      if (p) begin
        if (q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = q.pop_front();
          chk("id_pc", id_pc, e);
          chk("id_instr", id_instruction, word(e));
        end
      end
      if (redirect_valid) begin
        q.delete();
        mpc = redirect_pc & ~32'h3;
      end else if (imem_req) begin
        chk("imem_addr", imem_addr, mpc);
        q.push_back(mpc);
        mpc += 4;
      end
    end
  end

  initial begin
    rst_n = 0; id_ready = 1; redirect_valid = 0; redirect_pc = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); chk("c0_req", imem_req, 1); chk("c0_addr", imem_addr, 0); chk("c0_valid", id_valid, 0);
    @(negedge clk); chk("c1_valid", id_valid, 0); chk("c1_addr", imem_addr, 4);
    @(negedge clk); chk("c2_valid", id_valid, 1); chk("c2_pc", id_pc, 0);
    @(posedge clk); #1 id_ready = 0;
    @(negedge clk); h = id_pc; chk("c3_pc", h, 4);
    repeat (9) begin
      @(negedge clk); chk("stall_head", id_pc, h);
    end
    chk("stall_req", imem_req, 0);
    @(posedge clk); #1 id_ready = 1;
    repeat (8) @(posedge clk);
    #1 id_ready = 0;
    repeat (6) @(posedge clk);
    #1 id_ready = 1;
    @(negedge clk); chk("a_req", imem_req, 1);
    @(posedge clk); #1 id_ready = 0; redirect_valid = 1; redirect_pc = 32'h100;
    @(negedge clk); chk("b_valid", id_valid, 1); chk("b_req", imem_req, 0);
    @(posedge clk); #1 redirect_valid = 0; id_ready = 1;
    @(negedge clk); chk("r1_valid", id_valid, 0); chk("r1_req", imem_req, 1); chk("r1_addr", imem_addr, 32'h100);
    @(negedge clk); chk("r2_valid", id_valid, 0);
    @(negedge clk); chk("r3_valid", id_valid, 1); chk("r3_pc", id_pc, 32'h100);
    @(posedge clk); #1 redirect_valid = 1; redirect_pc = 32'h102;
    @(negedge clk); chk("m_valid", id_valid, 1);
    @(posedge clk); #1 redirect_valid = 0;
    @(negedge clk); chk("m1_valid", id_valid, 0); chk("m1_addr", imem_addr, 32'h100);
    @(negedge clk);
    @(negedge clk); chk("m3_pc", id_pc, 32'h100);
    @(posedge clk); #1 redirect_valid = 1; redirect_pc = 32'h200;
    @(posedge clk); #1 redirect_pc = 32'h300;
    @(posedge clk); #1 redirect_valid = 0;
    @(negedge clk); chk("bb_addr", imem_addr, 32'h300);
    @(negedge clk);
    @(negedge clk); chk("bb_pc", id_pc, 32'h300);
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    #1 chk("ar_valid", id_valid, 0); chk("ar_instr", id_instruction, 32'h0000_0013);
    chk("ar_pc", id_pc, 0); chk("ar_req", imem_req, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); chk("ar_restart", imem_addr, 0);
    repeat (300) begin
      @(posedge clk); #1
      id_ready       = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 19) == 0;
      redirect_pc    = $urandom;
    end
    @(posedge clk); #1 redirect_valid = 0; id_ready = 1;
    repeat (10) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
